// File: rtl/three_bit_count.sv
// Three-bit synchronous up-counter built from T flip-flop stages, clr is async active-high.
// Define THREE_BIT_COUNT_GRAY_EN to present the count as registered Gray code on q0..q2.
module three_bit_count #(
    parameter logic [2:0] RESET_VALUE = 3'b000
) (
    input  logic clk,
    input  logic clr,
    output logic q0,
    output logic q1,
    output logic q2
);

    function automatic logic [2:0] bin2gray(input logic [2:0] bin);
        return bin ^ {1'b0, bin[2:1]};
    endfunction

    // Declaration values give a defined count at power-up (flop INIT on FPGA).
    logic [2:0] r_cnt = RESET_VALUE;
    logic [2:0] w_tgl;
    logic [2:0] w_cnt_nxt;

    // Toggle enables of the three T stages, all sampled from the same edge.
    always_comb begin
        w_tgl     = {r_cnt[1] & r_cnt[0], r_cnt[0], 1'b1};
        w_cnt_nxt = r_cnt ^ w_tgl;
    end

    // Binary count register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= RESET_VALUE;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef THREE_BIT_COUNT_GRAY_EN
    localparam logic [2:0] GRAY_RESET = RESET_VALUE ^ {1'b0, RESET_VALUE[2:1]};

    logic [2:0] r_gray = GRAY_RESET;

    // Gray of the next count is registered on the same edge, so latency matches binary mode.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_gray <= GRAY_RESET;
        end else begin
            r_gray <= bin2gray(w_cnt_nxt);
        end
    end

    assign {q2, q1, q0} = r_gray;
`else
    assign {q2, q1, q0} = r_cnt;
`endif

endmodule

// File: tb/tb_three_bit_count.sv
// Self-checking bench for three_bit_count: arithmetic reference model checked every clk toggle,
// directed literal checks for power-up, wrap and reset cases, then randomized clr activity.
module tb_three_bit_count;

    localparam logic [2:0] RST = 3'b000;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic q0;
    logic q1;
    logic q2;

    int checks = 0;
    int errors = 0;

    int   model = int'(RST);
    logic clk_prev = 1'b0;
    int   n_chg = 0;
    time  last_chg_t = '1;
    bit   clr_seen = 1'b0;
    bit   glitch_armed = 1'b0;

    three_bit_count #(.RESET_VALUE(RST)) dut (
        .clk(clk),
        .clr(clr),
        .q0 (q0),
        .q1 (q1),
        .q2 (q2)
    );

    always #10 clk = ~clk;

    function automatic logic [2:0] enc(input int c);
`ifdef THREE_BIT_COUNT_GRAY_EN
        return 3'(c ^ (c >> 1));
`else
        return 3'(c);
`endif
    endfunction

    // Reference model: counts rising clk edges mod 8, forced to reset value while clr is high.
    always begin
        @(clk or clr);
        if (clr === 1'b1) begin
            model = int'(RST);
        end else if (clk === 1'b1 && clk_prev === 1'b0) begin
            model = (model + 1) % 8;
        end
        clk_prev = clk;
    end

    // Count distinct timesteps in which the output bus changes.
    always @(q0 or q1 or q2) begin
        if ($time != last_chg_t) n_chg++;
        last_chg_t = $time;
    end

    always @(posedge clr) clr_seen = 1'b1;

    // Compare process: checks outputs against the model after every clk toggle.
    always begin
        @(clk);
        #1;
        checks++;
        if ({q2, q1, q0} !== enc(model)) begin
            errors++;
            $display("FAIL model_cmp t=%0t got %b want %b", $time, {q2, q1, q0}, enc(model));
        end
        if (glitch_armed && !clr && !clr_seen) begin
            checks++;
            if (n_chg != (clk ? 1 : 0)) begin
                errors++;
                $display("FAIL glitch t=%0t change_steps %0d want %0d", $time, n_chg, (clk ? 1 : 0));
            end
        end
        n_chg = 0;
        clr_seen = 1'b0;
        glitch_armed = 1'b1;
    end

    task automatic chk_lit(input string name, input logic [2:0] exp_bin, input logic [2:0] exp_gray);
        logic [2:0] exp;
`ifdef THREE_BIT_COUNT_GRAY_EN
        exp = exp_gray;
`else
        exp = exp_bin;
`endif
        checks++;
        if ({q2, q1, q0} !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, {q2, q1, q0}, exp);
        end
    endtask

    initial begin
        logic [2:0] pu_bin  [13] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b011, 3'b011, 3'b100,
                                     3'b100, 3'b101, 3'b101, 3'b110, 3'b110, 3'b111};
        logic [2:0] pu_gray [13] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b010, 3'b010, 3'b110,
                                     3'b110, 3'b111, 3'b111, 3'b101, 3'b101, 3'b100};
        logic [2:0] s8_bin  [8]  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        logic [2:0] s8_gray [8]  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        // Free run from power-up, never touching clr.
        for (int i = 0; i < 13; i++) begin
            @(clk);
            #2;
            chk_lit("powerup", pu_bin[i], pu_gray[i]);
        end

        // Wrap from 111.
        @(posedge clk); #2; chk_lit("wrap_to_0", 3'b000, 3'b000);
        @(posedge clk); #2; chk_lit("wrap_then_1", 3'b001, 3'b001);

        // Advance to 101, then pulse clr mid-cycle with clk steady.
        repeat (4) @(posedge clk);
        #2; chk_lit("at_101", 3'b101, 3'b111);
        @(negedge clk);
        #3 clr = 1'b1;
        #1 chk_lit("async_clr", 3'b000, 3'b000);
        #2 clr = 1'b0;
        #2 chk_lit("pre_edge", 3'b000, 3'b000);
        @(posedge clk); #2; chk_lit("post_release", 3'b001, 3'b001);

        // clr held across five rising edges.
        @(negedge clk);
        #5 clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2; chk_lit("clr_held", 3'b000, 3'b000);
        end
        @(negedge clk);
        #5 clr = 1'b0;

        // Eight edges from reset.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2; chk_lit("seq8", s8_bin[i], s8_gray[i]);
        end

        // Randomized clr activity; the compare process checks every toggle.
        repeat (150) begin
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 12)) @(posedge clk);
                1: begin
                    @(negedge clk);
                    #($urandom_range(1, 6)) clr = 1'b1;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(negedge clk);
                    #($urandom_range(2, 8)) clr = 1'b0;
                end
                2: begin
                    @(posedge clk);
                    clr = 1'b1;
                    @(negedge clk);
                    #4 clr = 1'b0;
                end
                default: repeat ($urandom_range(1, 3)) @(negedge clk);
            endcase
        end

        repeat (3) @(posedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
